de_selector_rr: RTL and testbench
=================================

# de_selector_rr

Registered, parametrised 1-to-CH_N data distributor. It is the clocked successor of the combinational 1-to-4 de-selector. One DATA_W-bit input stream is steered to one of CH_N output channels, either by an explicit select (manual mode) or by an internal round-robin pointer (RR mode). Each channel has a one-entry output slot with a valid/ready handshake, so a stalled consumer back-pressures only beats aimed at its own channel.

## Interface
Parameters:
- DATA_W, 8, data width per channel
- CH_N, 4, number of output channels (2..16; need not be a power of two)
- SEL_W, $clog2(CH_N), select/pointer width (derived; do not override)

Ports:
- iClk  in  1  clock; all state updates on the rising edge
- iRst_n  in  1  asynchronous, active-low reset
- iC  in  DATA_W  input data beat
- iValid  in  1  iC holds a beat
- oReady  out  1  beat will be accepted this cycle (combinational)
- iMode  in  1  0 = manual (target = iS), 1 = round-robin (target = oPtr)
- iS  in  SEL_W  manual channel select
- iClr  in  1  synchronous flush: pointer to 0, all slots emptied
- oZ  out  CH_N*DATA_W  channel k data at [k*DATA_W +: DATA_W]
- oZValid  out  CH_N  slot k holds undelivered data
- iZReady  in  CH_N  consumer k takes slot k this cycle
- oPtr  out  SEL_W  current round-robin pointer
- oErr  out  1  one-cycle pulse: beat discarded because the manual select was out of range

## Operation
- Target: T = iMode ? oPtr : iS.
- oReady = ~iClr & (T >= CH_N | ~oZValid[T] | iZReady[T]).
- Accept = iValid & oReady.
- Accept with T < CH_N: slot T loads iC and sets oZValid[T] = 1.
- Accept with T >= CH_N (manual mode only): the beat is consumed and dropped, oErr = 1 for one cycle, and no slot changes.
- Slot k drains when oZValid[k] & iZReady[k]: oZValid[k] clears unless the same cycle accepts a new beat into k. In that case the data is replaced and valid stays 1 (full throughput).
- oZ[k] keeps its last delivered value after draining. It is never zeroed except by reset.
- The pointer advances only on an accept in RR mode: oPtr = (oPtr == CH_N-1) ? 0 : oPtr+1.
- In manual mode the pointer holds its value. A mode switch takes effect on the next cycle's target computation, with no pointer change.
- iClr: oPtr = 0 and all oZValid = 0 at the next edge. oReady is 0 during iClr, so no accept happens in that cycle. iClr wins over any drain or accept.
- iZReady[k] while oZValid[k] = 0 has no effect.

## Timing
- Reset (iRst_n low, asynchronous): oZ = 0, oZValid = 0, oPtr = 0, oErr = 0.
- Once reset is released with iClr = 0, oReady = 1.
- Reset mid-transfer discards all slot contents immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge t appears on oZ[T] with oZValid[T] = 1 right after edge t (1 cycle).
- Throughput: one beat per cycle, provided the target slot is empty or draining in the same cycle.
- oReady depends combinationally on iMode, iS, iClr, oZValid and iZReady. It has no dependency on iValid.
- oErr is registered: it is high during the cycle after the discarding accept.
- oZValid, oZ and oPtr are all registered. No combinational path runs from iC to oZ.

## Structure
- Shared package de_sel_pkg holds:
  - MODE_MANUAL = 1'b0 and MODE_RR = 1'b1
  - default DATA_W and CH_N constants
  - a function for next-pointer wrap (ptr, CH_N)
- Sub-module de_sel_slot is one per channel and is instantiated CH_N times by generate. It contains the DATA_W data register plus the valid flag, with inputs load, drain and flush, and outputs data and valid.
- The top level holds target decode, the oReady logic, the pointer register and the oErr register.

## Test plan
- Manual, CH_N=4, DATA_W=8, all iZReady=1: send iS=0,1,2,3 with iC=0xA0..0xA3 in consecutive cycles -> oZValid pulses 0001, 0010, 0100, 1000, and oZ[k] = 0xA0+k one cycle after each accept.
- RR mode, iZReady=1111: 6 beats 0x10..0x15 -> oPtr sequence 0,1,2,3,0,1,2. Channel 0 ends holding 0x14 and channel 1 ends holding 0x15.
- Back-pressure, RR mode: iZReady[1] = 0, channel 1 full -> oReady = 0 while oPtr = 1. When iZReady[1] = 1 with iValid = 1, the drain and the reload happen in the same cycle and oZValid[1] stays 1.
- CH_N=3, manual mode, iS=3, iValid=1 -> accepted, oErr = 1 the next cycle, and oZValid and oPtr are unchanged.
- Three slots full, iClr=1 together with iValid=1 -> oReady = 0. Next cycle: oZValid = 0, oPtr = 0, and oZ values are retained.
- Assert iRst_n low asynchronously between clock edges while slots are full -> all outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/de_sel_pkg.sv
// Shared constants and helpers for the registered round-robin de-selector.
// Mode encodings, default sizing and the pointer wrap function live here.
package de_sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH_N   = 4;

    // Wraps at ch_n rather than at a power of two, so odd channel counts work.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned ch_n);
        return (ptr == ch_n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/de_sel_slot.sv
// One-entry output slot: a data register plus a valid flag.
// Flush beats load beats drain; data is only ever overwritten by a load.
module de_sel_slot
    import de_sel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the data register is reset too, because the channel output must
    // read zero after reset; a plain storage array would normally skip this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
            if (load) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/de_selector_rr.sv
// Registered 1-to-CH_N distributor with manual or round-robin steering and
// per-channel valid/ready slots; a stalled channel only blocks beats aimed at it.
module de_selector_rr
    import de_sel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_N   = DEF_CH_N,
    parameter int SEL_W  = $clog2(CH_N)
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [DATA_W-1:0]        iC,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic                     iMode,
    input  logic [SEL_W-1:0]         iS,
    input  logic                     iClr,
    output logic [CH_N*DATA_W-1:0]   oZ,
    output logic [CH_N-1:0]          oZValid,
    input  logic [CH_N-1:0]          iZReady,
    output logic [SEL_W-1:0]         oPtr,
    output logic                     oErr
);

    localparam logic [SEL_W:0] CH_N_W = (SEL_W + 1)'(CH_N);

    logic [SEL_W-1:0] target;
    logic             in_range;
    logic [CH_N-1:0]  hit;
    logic             blocked;
    logic             accept;
    logic [SEL_W-1:0] ptr;
    logic             err;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit      = '0;
        target   = (iMode == MODE_RR) ? ptr : iS;
        in_range = ({1'b0, target} < CH_N_W);
        for (int k = 0; k < CH_N; k++) begin
            hit[k] = (target == SEL_W'(k));
        end
    end

    // An out-of-range target has no hit bit, so it is never blocked and is dropped.
    assign blocked = |(hit & oZValid & ~iZReady);
    assign oReady  = ~iClr & ~blocked;
    assign accept  = iValid & oReady;

    for (genvar g = 0; g < CH_N; g++) begin : g_slot
        de_sel_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (iClk),
            .rst_n     (iRst_n),
            .load      (accept & hit[g]),
            .drain     (iZReady[g]),
            .flush     (iClr),
            .load_data (iC),
            .data      (oZ[g*DATA_W +: DATA_W]),
            .valid     (oZValid[g])
        );
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr <= '0;
            err <= 1'b0;
        end else begin
            if (iClr) begin
                ptr <= '0;
            end else if (accept && iMode == MODE_RR) begin
                ptr <= SEL_W'(next_ptr(32'(ptr), CH_N));
            end
            err <= accept & ~in_range;
        end
    end

    assign oPtr = ptr;
    assign oErr = err;

endmodule

// File: tb/tb_de_selector_rr.sv
// Directed bench for de_selector_rr: a 4-channel instance for the main flows
// and a 3-channel instance for out-of-range selects and non-power-of-two wrap.
module tb_de_selector_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  c;
    logic        valid, ready, mode, clr, err;
    logic [1:0]  s, ptr;
    logic [31:0] z;
    logic [3:0]  z_valid, z_ready;

    logic [7:0]  c3;
    logic        valid3, ready3, mode3, clr3, err3;
    logic [1:0]  s3, ptr3;
    logic [23:0] z3;
    logic [2:0]  z_valid3, z_ready3;

    int n_checks = 0;
    int n_errors = 0;

    de_selector_rr #(.DATA_W(8), .CH_N(4)) dut (
        .iClk(clk), .iRst_n(rst_n), .iC(c), .iValid(valid), .oReady(ready),
        .iMode(mode), .iS(s), .iClr(clr), .oZ(z), .oZValid(z_valid),
        .iZReady(z_ready), .oPtr(ptr), .oErr(err)
    );

    de_selector_rr #(.DATA_W(8), .CH_N(3)) dut3 (
        .iClk(clk), .iRst_n(rst_n), .iC(c3), .iValid(valid3), .oReady(ready3),
        .iMode(mode3), .iS(s3), .iClr(clr3), .oZ(z3), .oZValid(z_valid3),
        .iZReady(z_ready3), .oPtr(ptr3), .oErr(err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        c = '0; valid = 0; mode = 0; clr = 0; s = '0; z_ready = '0;
        c3 = '0; valid3 = 0; mode3 = 0; clr3 = 0; s3 = '0; z_ready3 = '0;
        #3;
        n_checks++; if (z !== 32'h0) begin n_errors++; $display("FAIL rst_z: got %h exp %h", z, 32'h0); end
        n_checks++; if (z_valid !== 4'b0000) begin n_errors++; $display("FAIL rst_zvalid: got %b exp %b", z_valid, 4'b0000); end
        n_checks++; if (ptr !== 2'd0) begin n_errors++; $display("FAIL rst_ptr: got %0d exp 0", ptr); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b exp 0", err); end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b exp 1", ready); end
        n_checks++; if (ready3 !== 1'b1) begin n_errors++; $display("FAIL rst_ready3: got %b exp 1", ready3); end
    endtask

    task automatic test_manual();
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        mode = 0; z_ready = 4'b1111; valid = 1;
        for (int k = 0; k < 4; k++) begin
            s = k[1:0];
            c = 8'(8'hA0 + k);
            #1;
            n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL man_ready%0d: got %b exp 1", k, ready); end
            step();
            exp_v = 4'(1 << k);
            exp_d = 8'(8'hA0 + k);
            n_checks++; if (z_valid !== exp_v) begin n_errors++; $display("FAIL man_zvalid%0d: got %b exp %b", k, z_valid, exp_v); end
            n_checks++; if (z[k*8 +: 8] !== exp_d) begin n_errors++; $display("FAIL man_data%0d: got %h exp %h", k, z[k*8 +: 8], exp_d); end
            n_checks++; if (ptr !== 2'd0) begin n_errors++; $display("FAIL man_ptr%0d: got %0d exp 0", k, ptr); end
        end
        valid = 0;
        step();
        n_checks++; if (z_valid !== 4'b0000) begin n_errors++; $display("FAIL man_drained: got %b exp 0000", z_valid); end
        n_checks++; if (z !== 32'hA3A2A1A0) begin n_errors++; $display("FAIL man_retain: got %h exp %h", z, 32'hA3A2A1A0); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_p;
        mode = 1; z_ready = 4'b1111; valid = 1;
        for (int k = 0; k < 6; k++) begin
            c = 8'(8'h10 + k);
            exp_p = 2'(k % 4);
            #1;
            n_checks++; if (ptr !== exp_p) begin n_errors++; $display("FAIL rr_ptr%0d: got %0d exp %0d", k, ptr, exp_p); end
            step();
        end
        valid = 0;
        n_checks++; if (ptr !== 2'd2) begin n_errors++; $display("FAIL rr_ptr_end: got %0d exp 2", ptr); end
        step();
        n_checks++; if (z !== 32'h13121514) begin n_errors++; $display("FAIL rr_data: got %h exp %h", z, 32'h13121514); end
        n_checks++; if (ptr !== 2'd2) begin n_errors++; $display("FAIL rr_ptr_hold: got %0d exp 2", ptr); end
    endtask

    task automatic test_back_pressure();
        clr = 1; valid = 1; c = 8'hEE;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL bp_clr_ready: got %b exp 0", ready); end
        step();
        clr = 0;
        n_checks++; if (ptr !== 2'd0) begin n_errors++; $display("FAIL bp_clr_ptr: got %0d exp 0", ptr); end
        mode = 1; z_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            c = 8'(8'h20 + k);
            step();
        end
        c = 8'h25;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall_ready: got %b exp 0", ready); end
        n_checks++; if (ptr !== 2'd1) begin n_errors++; $display("FAIL bp_stall_ptr: got %0d exp 1", ptr); end
        step();
        n_checks++; if (z_valid !== 4'b0010) begin n_errors++; $display("FAIL bp_stall_zvalid: got %b exp 0010", z_valid); end
        n_checks++; if (z[15:8] !== 8'h21) begin n_errors++; $display("FAIL bp_stall_data: got %h exp 21", z[15:8]); end
        n_checks++; if (ptr !== 2'd1) begin n_errors++; $display("FAIL bp_stall_ptr2: got %0d exp 1", ptr); end
        z_ready = 4'b1111;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b exp 1", ready); end
        step();
        valid = 0;
        n_checks++; if (z_valid !== 4'b0010) begin n_errors++; $display("FAIL bp_reload_zvalid: got %b exp 0010", z_valid); end
        n_checks++; if (z[15:8] !== 8'h25) begin n_errors++; $display("FAIL bp_reload_data: got %h exp 25", z[15:8]); end
        n_checks++; if (ptr !== 2'd2) begin n_errors++; $display("FAIL bp_reload_ptr: got %0d exp 2", ptr); end
        step();
        n_checks++; if (z_valid !== 4'b0000) begin n_errors++; $display("FAIL bp_drain: got %b exp 0000", z_valid); end
    endtask

    task automatic test_clear();
        mode = 0; z_ready = 4'b0000; valid = 1;
        for (int k = 0; k < 3; k++) begin
            s = k[1:0];
            c = 8'(8'h30 + k);
            step();
        end
        n_checks++; if (z_valid !== 4'b0111) begin n_errors++; $display("FAIL clr_fill: got %b exp 0111", z_valid); end
        n_checks++; if (ptr !== 2'd2) begin n_errors++; $display("FAIL clr_ptr_before: got %0d exp 2", ptr); end
        clr = 1; s = 2'd3; c = 8'h33;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL clr_ready: got %b exp 0", ready); end
        step();
        clr = 0; valid = 0;
        n_checks++; if (z_valid !== 4'b0000) begin n_errors++; $display("FAIL clr_zvalid: got %b exp 0000", z_valid); end
        n_checks++; if (ptr !== 2'd0) begin n_errors++; $display("FAIL clr_ptr: got %0d exp 0", ptr); end
        n_checks++; if (z !== 32'h23323130) begin n_errors++; $display("FAIL clr_retain: got %h exp %h", z, 32'h23323130); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] exp_p;
        mode3 = 0; z_ready3 = 3'b000; valid3 = 1; s3 = 2'd0; c3 = 8'h40;
        step();
        s3 = 2'd3; c3 = 8'h41;
        #1;
        n_checks++; if (ready3 !== 1'b1) begin n_errors++; $display("FAIL oor_ready: got %b exp 1", ready3); end
        step();
        valid3 = 0;
        n_checks++; if (err3 !== 1'b1) begin n_errors++; $display("FAIL oor_err: got %b exp 1", err3); end
        n_checks++; if (z_valid3 !== 3'b001) begin n_errors++; $display("FAIL oor_zvalid: got %b exp 001", z_valid3); end
        n_checks++; if (ptr3 !== 2'd0) begin n_errors++; $display("FAIL oor_ptr: got %0d exp 0", ptr3); end
        n_checks++; if (z3 !== 24'h000040) begin n_errors++; $display("FAIL oor_data: got %h exp %h", z3, 24'h000040); end
        step();
        n_checks++; if (err3 !== 1'b0) begin n_errors++; $display("FAIL oor_err_pulse: got %b exp 0", err3); end
        mode3 = 1; z_ready3 = 3'b111; valid3 = 1;
        for (int k = 0; k < 4; k++) begin
            c3 = 8'(8'h50 + k);
            exp_p = 2'(k % 3);
            #1;
            n_checks++; if (ptr3 !== exp_p) begin n_errors++; $display("FAIL wrap3_ptr%0d: got %0d exp %0d", k, ptr3, exp_p); end
            step();
        end
        valid3 = 0;
        step();
        n_checks++; if (ptr3 !== 2'd1) begin n_errors++; $display("FAIL wrap3_ptr_end: got %0d exp 1", ptr3); end
        n_checks++; if (z3 !== 24'h525153) begin n_errors++; $display("FAIL wrap3_data: got %h exp %h", z3, 24'h525153); end
    endtask

    task automatic test_async_reset();
        mode = 1; z_ready = 4'b0000; valid = 1;
        for (int k = 0; k < 3; k++) begin
            c = 8'(8'h60 + k);
            step();
        end
        valid = 0;
        n_checks++; if (z_valid !== 4'b0111) begin n_errors++; $display("FAIL ar_fill: got %b exp 0111", z_valid); end
        n_checks++; if (ptr !== 2'd3) begin n_errors++; $display("FAIL ar_ptr_before: got %0d exp 3", ptr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (z !== 32'h0) begin n_errors++; $display("FAIL ar_z: got %h exp 0", z); end
        n_checks++; if (z_valid !== 4'b0000) begin n_errors++; $display("FAIL ar_zvalid: got %b exp 0000", z_valid); end
        n_checks++; if (ptr !== 2'd0) begin n_errors++; $display("FAIL ar_ptr: got %0d exp 0", ptr); end
        n_checks++; if (z3 !== 24'h0) begin n_errors++; $display("FAIL ar_z3: got %h exp 0", z3); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL ar_ready: got %b exp 1", ready); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ar_err: got %b exp 0", err); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_round_robin();
        test_back_pressure();
        test_clear();
        test_out_of_range();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
